conv_interleaver: RTL and testbench

Parametrised Forney convolutional interleaver/deinterleaver for the DVB-C byte path, placed between the RS encoder and the byte-to-symbol mapper (or mirrored in a receiver model). Branch count, cell depth and data width are parameters; direction is selected per instance at clear time. All branch FIFOs share one dual-port RAM, and a post-reset clear sequence zero-fills the RAM so that output is deterministic from the first byte.

---
 rtl/dvbc_pkg.sv | 30 +++
 rtl/conv_interleaver_if.sv | 24 ++
 rtl/dp_ram.sv | 22 ++
 rtl/conv_interleaver.sv | 143 ++++++++++++++
 tb/tb_conv_interleaver.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvbc_pkg.sv
// Shared constants, mode encoding and branch geometry helpers for the
// DVB-C convolutional interleaver.
package dvbc_pkg;

  localparam int DEF_I     = 12;
  localparam int DEF_M     = 17;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    MODE_INTLV   = 1'b0,
    MODE_DEINTLV = 1'b1
  } modeT;

  function automatic int totalWords(input int nI, input int nM);
    return nM * nI * (nI - 1) / 2;
  endfunction

  function automatic int depth(input int j, input modeT mode, input int nI, input int nM);
    return (mode == MODE_INTLV) ? j * nM : (nI - 1 - j) * nM;
  endfunction

  // Branches are packed back to back in RAM in branch order.
  function automatic int base(input int j, input modeT mode, input int nI, input int nM);
    int acc;
    acc = 0;
    for (int k = 0; k < j; k++) acc += depth(k, mode, nI, nM);
    return acc;
  endfunction

endpackage

// File: rtl/conv_interleaver_if.sv
// Byte-stream bus of the interleaver: input bytes with sync marker, output
// bytes with sync marker and sync-error pulse.
interface conv_interleaver_if #(
  parameter int WIDTH = 8
);
  logic             iValid;
  logic [WIDTH-1:0] iData;
  logic             iPSync;
  logic             oReady;
  logic             oValid;
  logic [WIDTH-1:0] oData;
  logic             oPSync;
  logic             oSyncErr;

  modport master (
    output iValid, iData, iPSync,
    input  oReady, oValid, oData, oPSync, oSyncErr
  );

  modport slave (
    input  iValid, iData, iPSync,
    output oReady, oValid, oData, oPSync, oSyncErr
  );
endinterface

// File: rtl/dp_ram.sv
// Simple dual-port RAM with registered read; a read of the address being
// written in the same cycle returns the old word.
module dp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1122,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/conv_interleaver.sv
// Forney convolutional interleaver/deinterleaver: I stepped-depth branch FIFOs
// sharing one dual-port RAM, zero-filled by a clear pass after every reset.
//   state    | meaning
//   ST_CLEAR | write 0 to RAM word clrCnt each cycle, inputs ignored
//   ST_RUN   | accept bytes, rotate through the branches
module conv_interleaver
  import dvbc_pkg::*;
#(
  parameter int I     = DEF_I,
  parameter int M     = DEF_M,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic iClk,
  input logic iClrn,
  input logic iMode,
  conv_interleaver_if.slave bus
);
  localparam int TOTAL = totalWords(I, M);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW    = $clog2(I * M);
  localparam int BW    = $clog2(I);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       state;
  modeT             mode;
  logic             modeIdx;
  logic [AW-1:0]    clrCnt;
  logic [BW-1:0]    brCnt;
  logic [BW-1:0]    br;
  logic [PW-1:0]    ptr [I];

  logic [AW-1:0]    baseTab [2][I];
  logic [PW-1:0]    lastTab [2][I];
  logic             bypTab  [2][I];

  // Per-mode branch geometry is fixed at elaboration; only the mode bit selects.
  for (genvar m = 0; m < 2; m++) begin : gMode
    for (genvar j = 0; j < I; j++) begin : gBranch
      localparam modeT GM = modeT'(m);
      localparam int   D  = depth(j, GM, I, M);
      assign baseTab[m][j] = AW'(base(j, GM, I, M));
      assign lastTab[m][j] = PW'((D > 0) ? D - 1 : 0);
      assign bypTab[m][j]  = (D == 0);
    end
  end

  logic             accept;
  logic             syncErr;
  logic             byp;
  logic             ramEn;
  logic             wrEn;
  logic [AW-1:0]    ramAddr;
  logic [AW-1:0]    wrAddr;
  logic [WIDTH-1:0] wrData;
  logic [WIDTH-1:0] ramQ;

  assign modeIdx = (mode == MODE_DEINTLV);
  assign accept  = bus.iValid && bus.oReady;
  assign syncErr = accept && bus.iPSync && (brCnt != '0);
  assign br      = syncErr ? '0 : brCnt;
  assign byp     = bypTab[modeIdx][br];
  assign ramEn   = accept && !byp && !iClrn;
  assign ramAddr = baseTab[modeIdx][br] + AW'(ptr[br]);
  assign wrEn    = ramEn || (state == ST_CLEAR && !iClrn);

  always_comb begin
    wrAddr = ramAddr;
    wrData = bus.iData;
    if (state == ST_CLEAR) begin
      wrAddr = clrCnt;
      wrData = '0;
    end
  end

  dp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (TOTAL),
    .AW    (AW)
  ) uRam (
    .clk    (iClk),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdEn   (ramEn),
    .rdAddr (ramAddr),
    .rdData (ramQ)
  );

  always_ff @(posedge iClk) begin
    if (iClrn) begin
      state      <= ST_CLEAR;
      clrCnt     <= '0;
      brCnt      <= '0;
      mode       <= modeT'(iMode);
      bus.oReady <= 1'b0;
      for (int j = 0; j < I; j++) ptr[j] <= '0;
    end else begin
      bus.oReady <= (state == ST_RUN);
      if (state == ST_CLEAR) begin
        mode   <= modeT'(iMode);
        clrCnt <= clrCnt + 1'b1;
        if (clrCnt == AW'(TOTAL - 1)) state <= ST_RUN;
      end
      if (accept) begin
        brCnt <= (br == BW'(I - 1)) ? '0 : br + 1'b1;
        if (!byp) ptr[br] <= (ptr[br] == lastTab[modeIdx][br]) ? '0 : ptr[br] + 1'b1;
      end
    end
  end

  // Bypass bytes ride a register stage alongside the RAM read to keep latency fixed.
  logic             v1;
  logic             byp1;
  logic             sync1;
  logic             err1;
  logic [WIDTH-1:0] bypData1;

  always_ff @(posedge iClk) begin
    if (iClrn) begin
      v1           <= 1'b0;
      byp1         <= 1'b0;
      sync1        <= 1'b0;
      err1         <= 1'b0;
      bypData1     <= '0;
      bus.oValid   <= 1'b0;
      bus.oData    <= '0;
      bus.oPSync   <= 1'b0;
      bus.oSyncErr <= 1'b0;
    end else begin
      v1           <= accept;
      byp1         <= byp;
      sync1        <= accept && bus.iPSync;
      err1         <= syncErr;
      bypData1     <= bus.iData;
      bus.oValid   <= v1;
      bus.oPSync   <= v1 && sync1;
      bus.oSyncErr <= v1 && err1;
      if (v1) bus.oData <= byp1 ? bypData1 : ramQ;
    end
  end
endmodule

// File: tb/tb_conv_interleaver.sv
// Bench for conv_interleaver: per-branch delay model feeding a scoreboard,
// plus a table of hand-derived output slots for both modes.
module tb_conv_interleaver;
  import dvbc_pkg::*;

  localparam int I     = 12;
  localparam int M     = 17;
  localparam int WIDTH = 8;
  localparam int PKT   = 204;
  localparam int TOTAL = totalWords(I, M);
  localparam int HMAX  = 512;

  logic iClk  = 1'b0;
  logic iClrn = 1'b1;
  logic iMode = 1'b0;

  conv_interleaver_if #(.WIDTH(WIDTH)) bus ();

  conv_interleaver #(
    .I     (I),
    .M     (M),
    .WIDTH (WIDTH)
  ) dut (
    .iClk  (iClk),
    .iClrn (iClrn),
    .iMode (iMode),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       pSync;
    logic       syncErr;
    int         cyc;
    int         slot;
  } expT;

  typedef struct {
    int         phase;
    int         slot;
    logic [7:0] data;
  } spotT;

  expT        sbq [$];
  spotT       spots [16];
  int         nCmp = 0;
  int         nErr = 0;
  int         errPulses = 0;
  int         phase = 0;
  int         inSlot = 0;
  int         mMode = 0;
  int         mBr = 0;
  int         nIn [I];
  logic [7:0] hist [I][HMAX];
  logic [7:0] capt [2][4096];

  function automatic int dly(input int j);
    return ((mMode == 0) ? j : (I - 1 - j)) * M;
  endfunction

  task automatic modelReset(input int md);
    mMode  = md;
    mBr    = 0;
    inSlot = 0;
    for (int j = 0; j < I; j++) nIn[j] = 0;
  endtask

  // Called just after a rising edge; the byte is sampled at the next edge.
  task automatic drive(input logic [7:0] d, input logic ps);
    expT e;
    int  b;
    int  k;
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iPSync = ps;
    if (bus.oReady === 1'b1) begin
      b = mBr;
      e.syncErr = 1'b0;
      if (ps && mBr != 0) begin
        b = 0;
        e.syncErr = 1'b1;
      end
      k = nIn[b];
      if (k < HMAX) hist[b][k] = d;
      nIn[b] = k + 1;
      e.data  = (k >= dly(b)) ? hist[b][k - dly(b)] : 8'd0;
      e.pSync = ps;
      e.cyc   = cyc + 2;
      e.slot  = inSlot;
      sbq.push_back(e);
      inSlot = inSlot + 1;
      mBr = (b == I - 1) ? 0 : b + 1;
    end
  endtask

  task automatic stream(input int n, input int maxGap, input int syncRef);
    for (int i = 0; i < n; i++) begin
      int   gap;
      logic ps;
      gap = (maxGap > 0) ? $urandom_range(maxGap, 0) : 0;
      repeat (gap) begin
        bus.iValid = 1'b0;
        bus.iPSync = 1'b0;
        @(posedge iClk);
        #1;
      end
      ps = (inSlot >= syncRef) && ((inSlot - syncRef) % PKT == 0);
      drive(8'(inSlot), ps);
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic applyReset(input logic md, input int holdCyc, input bit midStream);
    int bad;
    iClrn      = 1'b1;
    iMode      = md;
    bus.iValid = 1'b0;
    bus.iPSync = 1'b0;
    bus.iData  = '0;
    @(posedge iClk);
    #1;
    nCmp++;
    if (bus.oValid !== 1'b0) begin
      nErr++;
      $display("FAIL reset_ovalid_drop: oValid=%b, expected 0", bus.oValid);
    end
    if (midStream) begin
      nCmp++;
      if (sbq.size() != 1) begin
        nErr++;
        $display("FAIL reset_inflight: %0d pending, expected 1", sbq.size());
      end
    end
    sbq.delete();
    modelReset(md);
    phase = md;
    repeat (holdCyc - 1) @(posedge iClk);
    #1;
    nCmp++;
    if ({bus.oReady, bus.oValid, bus.oData, bus.oPSync, bus.oSyncErr} !== '0) begin
      nErr++;
      $display("FAIL reset_outputs: got %b, expected all 0",
               {bus.oReady, bus.oValid, bus.oData, bus.oPSync, bus.oSyncErr});
    end
    iClrn = 1'b0;
    bad = 0;
    for (int k = 1; k <= TOTAL + 1; k++) begin
      @(posedge iClk);
      #1;
      if (k <= TOTAL &&
          {bus.oReady, bus.oValid, bus.oData, bus.oPSync, bus.oSyncErr} !== '0) bad++;
    end
    nCmp++;
    if (bad != 0) begin
      nErr++;
      $display("FAIL clear_quiet: %0d cycles with outputs active before cycle %0d, expected 0",
               bad, TOTAL + 1);
    end
    nCmp++;
    if (bus.oReady !== 1'b1) begin
      nErr++;
      $display("FAIL ready_rise: oReady=%b at cycle %0d, expected 1", bus.oReady, TOTAL + 1);
    end
  endtask

  always @(negedge iClk) begin
    expT e;
    if (bus.oSyncErr === 1'b1) errPulses++;
    if (bus.oValid === 1'b1) begin
      if (sbq.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected_output: data=%0d with empty scoreboard", bus.oData);
      end else begin
        e = sbq.pop_front();
        nCmp++;
        if (bus.oData !== e.data || bus.oPSync !== e.pSync ||
            bus.oSyncErr !== e.syncErr || cyc != e.cyc) begin
          nErr++;
          $display("FAIL out_slot%0d: got data=%0d ps=%b err=%b cyc=%0d, expected data=%0d ps=%b err=%b cyc=%0d",
                   e.slot, bus.oData, bus.oPSync, bus.oSyncErr, cyc,
                   e.data, e.pSync, e.syncErr, e.cyc);
        end
        if (e.slot < 4096) capt[phase][e.slot] = bus.oData;
      end
    end else if (bus.oPSync === 1'b1 || bus.oSyncErr === 1'b1) begin
      nCmp++;
      nErr++;
      $display("FAIL stray_marker: oPSync=%b oSyncErr=%b without oValid", bus.oPSync, bus.oSyncErr);
    end
  end

  initial begin
    spots[0]  = '{0,    0, 8'd0};
    spots[1]  = '{0,    1, 8'd0};
    spots[2]  = '{0,   12, 8'd12};
    spots[3]  = '{0,  205, 8'd1};
    spots[4]  = '{0,  409, 8'd205};
    spots[5]  = '{0, 2000, 8'd112};
    spots[6]  = '{0, 2243, 8'd0};
    spots[7]  = '{0, 2255, 8'd11};
    spots[8]  = '{0, 2700, 8'd140};
    spots[9]  = '{0, 3001, 8'd237};
    spots[10] = '{0, 3199, 8'd235};
    spots[11] = '{1,   11, 8'd11};
    spots[12] = '{1, 1000, 8'd0};
    spots[13] = '{1, 2255, 8'd207};
    spots[14] = '{1, 2256, 8'd12};
    spots[15] = '{1, 2401, 8'd105};

    bus.iValid = 1'b0;
    bus.iData  = '0;
    bus.iPSync = 1'b0;
    @(posedge iClk);
    #1;

    applyReset(1'b0, 3, 1'b0);
    stream(2600, 0, 0);
    stream(600, 5, 0);
    stream(400, 0, 3205);
    nCmp++;
    if (errPulses != 1) begin
      nErr++;
      $display("FAIL sync_err_count: %0d pulses, expected 1", errPulses);
    end

    applyReset(1'b1, 2, 1'b1);
    stream(2500, 0, 0);
    bus.iValid = 1'b0;
    bus.iPSync = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    nCmp++;
    if (sbq.size() != 0) begin
      nErr++;
      $display("FAIL drain: %0d outputs missing, expected 0", sbq.size());
    end
    nCmp++;
    if (errPulses != 1) begin
      nErr++;
      $display("FAIL deint_sync_err: %0d pulses total, expected 1", errPulses);
    end

    for (int i = 0; i < 16; i++) begin
      nCmp++;
      if (capt[spots[i].phase][spots[i].slot] !== spots[i].data) begin
        nErr++;
        $display("FAIL spot_mode%0d_slot%0d: got %0d, expected %0d", spots[i].phase,
                 spots[i].slot, capt[spots[i].phase][spots[i].slot], spots[i].data);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
